// File: rtl/cordic_iter_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Shared types and elaboration-time constants for the CORDIC engine.
// Revision : 1.0
// ============================================================================
package cordic_pkg;

    typedef enum logic {
        ROTATE = 1'b0,
        VECTOR = 1'b1
    } cordic_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cordic_state_e;

    localparam int     CORDIC_Q          = 60;
    localparam longint CORDIC_K_Q32      = 64'sd2608131496;
    localparam int     DEFAULT_FRAC_BITS = 22;

    // atan(1/n) in Q60 by its alternating power series
    function automatic longint atan_inv_q60(input longint n);
        longint p;
        longint acc;
        p   = (64'sd1 <<< CORDIC_Q) / n;
        acc = 64'sd0;
        for (int k = 0; k < 32; k++) begin
            if (k[0]) acc = acc - p / longint'(2 * k + 1);
            else      acc = acc + p / longint'(2 * k + 1);
            p = p / (n * n);
        end
        return acc;
    endfunction

    function automatic longint atan_lut(input int i, input int width, input int frac_bits);
        longint q60;
        longint r;
        if (i == 0)             q60 = 4 * atan_inv_q60(64'sd5) - atan_inv_q60(64'sd239);
        else if (i < 30)        q60 = atan_inv_q60(64'sd1 <<< i);
        else if (i < CORDIC_Q)  q60 = 64'sd1 <<< (CORDIC_Q - i);
        else                    q60 = 64'sd0;
        r = (q60 + (64'sd1 <<< (CORDIC_Q - 1 - frac_bits))) >>> (CORDIC_Q - frac_bits);
        if (r > (64'sd1 <<< (width - 1)) - 64'sd1) r = (64'sd1 <<< (width - 1)) - 64'sd1;
        return r;
    endfunction

    function automatic longint cordic_k_q(input int frac_bits);
        return (CORDIC_K_Q32 + (64'sd1 <<< (31 - frac_bits))) >>> (32 - frac_bits);
    endfunction

    localparam longint CORDIC_K_Q = cordic_k_q(DEFAULT_FRAC_BITS);

endpackage
`default_nettype wire

// File: rtl/cordic_iter_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_engine_if
// Purpose  : Operand/result valid-ready bundle of the CORDIC engine.
// Revision : 1.0
// ============================================================================
interface cordic_iter_engine_if #(
    parameter int WIDTH = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic signed [WIDTH-1:0] in_x;
    logic signed [WIDTH-1:0] in_y;
    logic signed [WIDTH-1:0] in_z;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_x;
    logic signed [WIDTH-1:0] out_y;
    logic signed [WIDTH-1:0] out_z;
    logic                    busy;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, busy
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, busy
    );
endinterface
`default_nettype wire

// File: rtl/cordic_iter_engine_stage.sv
`default_nettype none
// ============================================================================
// Module   : cordic_stage
// Purpose  : One combinational CORDIC micro-rotation with a runtime index.
// Revision : 1.0
// ============================================================================
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int FRAC_BITS = 22,
    parameter int CORD_ITER = 16,
    parameter int IDX_W     = 4
) (
    input  wire logic                    i_mode,
    input  wire logic [IDX_W-1:0]        i_idx,
    input  wire logic signed [WIDTH-1:0] i_x,
    input  wire logic signed [WIDTH-1:0] i_y,
    input  wire logic signed [WIDTH-1:0] i_z,
    output logic signed [WIDTH-1:0]      o_x,
    output logic signed [WIDTH-1:0]      o_y,
    output logic signed [WIDTH-1:0]      o_z
);
    logic signed [WIDTH-1:0] w_atan [CORD_ITER];

    for (genvar g = 0; g < CORD_ITER; g++) begin : g_atan
        localparam logic signed [WIDTH-1:0] C_ATAN = WIDTH'(atan_lut(g, WIDTH, FRAC_BITS));
        assign w_atan[g] = C_ATAN;
    end

    logic                    w_pos;
    logic signed [WIDTH-1:0] w_xs;
    logic signed [WIDTH-1:0] w_ys;
    logic signed [WIDTH-1:0] w_ang;

    always_comb begin
        // vectoring drives y toward zero, rotation drives z toward zero
        w_pos = (i_mode == VECTOR) ? i_y[WIDTH-1] : ~i_z[WIDTH-1];
        w_xs  = i_x >>> i_idx;
        w_ys  = i_y >>> i_idx;
        w_ang = w_atan[i_idx];
        if (w_pos) begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - w_ang;
        end else begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + w_ang;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_engine
// Purpose  : Folded CORDIC, ITER_PER_CYCLE unrolled stages per clock.
// Revision : 1.0
// ============================================================================
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH          = 24,
    parameter int FRAC_BITS      = 22,
    parameter int CORD_ITER      = 16,
    parameter int ITER_PER_CYCLE = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cordic_iter_engine_if.slave bus
);
    localparam int N_CYC = CORD_ITER / ITER_PER_CYCLE;
    localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam int IDX_W = (CORD_ITER > 1) ? $clog2(CORD_ITER) : 1;

    if (CORD_ITER % ITER_PER_CYCLE != 0) begin : g_chk_fold
        $error("CORD_ITER must be a multiple of ITER_PER_CYCLE");
    end
    if (CORD_ITER > WIDTH) begin : g_chk_iter
        $error("CORD_ITER must not exceed WIDTH");
    end
    if (FRAC_BITS >= WIDTH - 1) begin : g_chk_frac
        $error("FRAC_BITS must be below WIDTH-1");
    end

    cordic_state_e           state_q, state_d;
    cordic_mode_e            mode_q, mode_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    idle_rdy_q, idle_rdy_d;

    logic signed [WIDTH-1:0] w_cx [ITER_PER_CYCLE+1];
    logic signed [WIDTH-1:0] w_cy [ITER_PER_CYCLE+1];
    logic signed [WIDTH-1:0] w_cz [ITER_PER_CYCLE+1];

    assign w_cx[0] = x_q;
    assign w_cy[0] = y_q;
    assign w_cz[0] = z_q;

    for (genvar j = 0; j < ITER_PER_CYCLE; j++) begin : g_stage
        logic [IDX_W-1:0] w_idx;
        assign w_idx = IDX_W'(int'(cnt_q) * ITER_PER_CYCLE + j);
        cordic_stage #(
            .WIDTH     (WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .CORD_ITER (CORD_ITER),
            .IDX_W     (IDX_W)
        ) u_stage (
            .i_mode (mode_q),
            .i_idx  (w_idx),
            .i_x    (w_cx[j]),
            .i_y    (w_cy[j]),
            .i_z    (w_cz[j]),
            .o_x    (w_cx[j+1]),
            .o_y    (w_cy[j+1]),
            .o_z    (w_cz[j+1])
        );
    end

    // DONE hands in_ready straight to the consumer so a new operand can chase the result out
    assign bus.in_ready  = idle_rdy_q | ((state_q == DONE) & bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_x     = ox_q;
    assign bus.out_y     = oy_q;
    assign bus.out_z     = oz_q;
    assign bus.busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        oz_d        = oz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    mode_d  = cordic_mode_e'(bus.in_mode);
                    cnt_d   = '0;
                    x_d     = bus.in_x;
                    y_d     = bus.in_y;
                    z_d     = bus.in_z;
                end
            end
            RUN: begin
                x_d   = w_cx[ITER_PER_CYCLE];
                y_d   = w_cy[ITER_PER_CYCLE];
                z_d   = w_cz[ITER_PER_CYCLE];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_CYC - 1)) begin
                    state_d     = DONE;
                    ox_d        = w_cx[ITER_PER_CYCLE];
                    oy_d        = w_cy[ITER_PER_CYCLE];
                    oz_d        = w_cz[ITER_PER_CYCLE];
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        state_d = RUN;
                        mode_d  = cordic_mode_e'(bus.in_mode);
                        cnt_d   = '0;
                        x_d     = bus.in_x;
                        y_d     = bus.in_y;
                        z_d     = bus.in_z;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        idle_rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= ROTATE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            oz_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            idle_rdy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            oz_q        <= oz_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            idle_rdy_q  <= idle_rdy_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_iter_engine
// Purpose  : Self-checking bench for the folded CORDIC engine.
// Revision : 1.0
// ============================================================================
module tb_cordic_iter_engine;
    localparam int W     = 24;
    localparam int FRAC  = 22;
    localparam int ITER  = 16;
    localparam int IPC   = 4;
    localparam int N     = ITER / IPC;
    localparam int TOL   = 256;
    localparam int K_Q   = 2547003;
    localparam int PI_2  = 6588397;
    localparam int PI_4  = 3294199;
    localparam int ONE   = 4194304;

    typedef struct {
        logic signed [W-1:0] x, y, z;
        logic                has_ana;
        int                  ax, ay, az;
    } exp_t;

    typedef struct {
        logic mode;
        int   x, y, z;
        logic has_ana;
        int   ax, ay, az;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic signed [W-1:0] atan_tb [ITER];

    always #5 clk = ~clk;

    cordic_iter_engine_if #(.WIDTH(W)) ifm ();

    cordic_iter_engine #(
        .WIDTH(W), .FRAC_BITS(FRAC), .CORD_ITER(ITER), .ITER_PER_CYCLE(IPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm)
    );

    // latency sweep instances share one stimulus
    logic                sw_valid = 1'b0;
    logic                sw_ready = 1'b0;
    logic signed [W-1:0] sw_x = '0, sw_y = '0, sw_z = '0;
    logic [2:0]          sw_ov;
    logic signed [W-1:0] sw_ox [3];
    logic signed [W-1:0] sw_oy [3];
    logic signed [W-1:0] sw_oz [3];

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW_IPC = (g == 0) ? 1 : ((g == 1) ? 2 : 16);
        cordic_iter_engine_if #(.WIDTH(W)) sif ();
        assign sif.in_valid  = sw_valid;
        assign sif.in_mode   = 1'b0;
        assign sif.in_x      = sw_x;
        assign sif.in_y      = sw_y;
        assign sif.in_z      = sw_z;
        assign sif.out_ready = sw_ready;
        assign sw_ov[g]      = sif.out_valid;
        assign sw_ox[g]      = sif.out_x;
        assign sw_oy[g]      = sif.out_y;
        assign sw_oz[g]      = sif.out_z;
        cordic_iter_engine #(
            .WIDTH(W), .FRAC_BITS(FRAC), .CORD_ITER(ITER), .ITER_PER_CYCLE(SW_IPC)
        ) u_sw (
            .clk   (clk),
            .reset (reset),
            .bus   (sif)
        );
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint exp);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        checks++;
        if (d > TOL) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d+/-%0d", name, act, exp, TOL);
        end
    endtask

    function automatic void model(input logic mode, input logic signed [W-1:0] x0, y0, z0,
                                  output logic signed [W-1:0] xr, yr, zr);
        logic signed [W-1:0] x, y, z, xs, ys;
        logic d;
        x = x0; y = y0; z = z0;
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            d  = mode ? y[W-1] : ~z[W-1];
            if (d) begin x = x - ys; y = y + xs; z = z - atan_tb[i]; end
            else   begin x = x + ys; y = y - xs; z = z + atan_tb[i]; end
        end
        xr = x; yr = y; zr = z;
    endfunction

    // scoreboard: one pop per completed output handshake
    always @(negedge clk) begin
        if (!reset && ifm.out_valid && ifm.out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_result actual_x=%0d expected=none", ifm.out_x);
            end else begin
                mon_e = sb_q.pop_front();
                chk("res_x", ifm.out_x, mon_e.x);
                chk("res_y", ifm.out_y, mon_e.y);
                chk("res_z", ifm.out_z, mon_e.z);
                if (mon_e.has_ana) begin
                    chk_tol("ana_x", ifm.out_x, mon_e.ax);
                    chk_tol("ana_y", ifm.out_y, mon_e.ay);
                    chk_tol("ana_z", ifm.out_z, mon_e.az);
                end
            end
        end
    end

    task automatic drive_op(input logic mode, input int x, input int y, input int z,
                            input logic has_ana, input int ax, input int ay, input int az);
        exp_t e;
        logic acc;
        model(mode, W'(x), W'(y), W'(z), e.x, e.y, e.z);
        e.has_ana = has_ana; e.ax = ax; e.ay = ay; e.az = az;
        sb_q.push_back(e);
        ifm.in_mode = mode; ifm.in_x = W'(x); ifm.in_y = W'(y); ifm.in_z = W'(z);
        ifm.in_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            if (ifm.in_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
            end
        end
        ifm.in_valid = 1'b0;
        if (!acc) begin
            void'(sb_q.pop_back());
            chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            if (ifm.out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    vec_t vecs [8];
    int   lat;
    int   sw_lat [3];
    logic signed [W-1:0] ex, ey, ez;

    initial begin
        for (int i = 0; i < ITER; i++)
            atan_tb[i] = W'(longint'($atan(2.0 ** (-i)) * (2.0 ** FRAC)));

        vecs[0] = '{1'b0, K_Q, 0, PI_2, 1'b1, 0, ONE, 0};
        vecs[1] = '{1'b1, 2097152, 2097152, 0, 1'b1, 4883960, 0, PI_4};
        vecs[2] = '{1'b0, K_Q, 0, -PI_4, 1'b1, 2965821, -2965821, 0};
        vecs[3] = '{1'b0, K_Q, 0, 0, 1'b1, ONE, 0, 0};
        vecs[4] = '{1'b1, ONE, 0, 0, 1'b1, 6906993, 0, 0};
        vecs[5] = '{1'b1, 2097152, -2097152, 0, 1'b1, 4883960, 0, -PI_4};
        vecs[6] = '{1'b0, K_Q, 0, 8000000, 1'b0, 0, 0, 0};
        vecs[7] = '{1'b1, -2097152, 1000000, 12345, 1'b0, 0, 0, 0};

        ifm.in_valid = 1'b0; ifm.in_mode = 1'b0;
        ifm.in_x = '0; ifm.in_y = '0; ifm.in_z = '0;
        ifm.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ifm.out_valid, 0);
        chk("rst_busy", ifm.busy, 0);
        chk("rst_in_ready", ifm.in_ready, 0);
        chk("rst_out_x", ifm.out_x, 0);
        chk("rst_out_y", ifm.out_y, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", ifm.in_ready, 1);

        // table of operands with free-running consumer
        ifm.out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive_op(vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].z,
                     vecs[i].has_ana, vecs[i].ax, vecs[i].ay, vecs[i].az);
            chk("busy_run", ifm.busy, 1);
            chk("in_ready_run", ifm.in_ready, 0);
            wait_out(lat);
            chk("latency", lat, N);
            @(posedge clk);
            #1;
        end
        chk("idle_busy", ifm.busy, 0);

        // backpressure, then back-to-back accept on the consuming edge
        ifm.out_ready = 1'b0;
        drive_op(1'b0, K_Q, 0, PI_2, 1'b1, 0, ONE, 0);
        wait_out(lat);
        chk("bp_latency", lat, N);
        model(1'b0, W'(K_Q), W'(0), W'(PI_2), ex, ey, ez);
        for (int c = 0; c < 5; c++) begin
            ifm.in_valid = 1'b1;
            ifm.in_mode  = 1'b1;
            ifm.in_x = W'($urandom); ifm.in_y = W'($urandom); ifm.in_z = W'($urandom);
            @(negedge clk);
            chk("bp_in_ready", ifm.in_ready, 0);
            chk("bp_out_valid", ifm.out_valid, 1);
            chk("bp_hold_x", ifm.out_x, ex);
            chk("bp_hold_y", ifm.out_y, ey);
            chk("bp_hold_z", ifm.out_z, ez);
            @(posedge clk);
            #1;
        end
        ifm.in_valid = 1'b0;
        ifm.out_ready = 1'b1;
        drive_op(1'b1, 2097152, 2097152, 0, 1'b1, 4883960, 0, PI_4);
        chk("b2b_busy", ifm.busy, 1);
        chk("b2b_out_valid_drop", ifm.out_valid, 0);
        wait_out(lat);
        chk("b2b_latency", lat, N);
        @(posedge clk);
        #1;

        // asynchronous reset in the second RUN cycle abandons the operation
        drive_op(1'b0, K_Q, 0, PI_4, 1'b0, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", ifm.out_valid, 0);
        chk("arst_out_x", ifm.out_x, 0);
        chk("arst_out_y", ifm.out_y, 0);
        chk("arst_out_z", ifm.out_z, 0);
        chk("arst_busy", ifm.busy, 0);
        chk("arst_in_ready", ifm.in_ready, 0);
        void'(sb_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_rel_in_ready", ifm.in_ready, 1);
        drive_op(1'b0, K_Q, 0, 0, 1'b1, ONE, 0, 0);
        wait_out(lat);
        chk("arst_fresh_latency", lat, N);
        @(posedge clk);
        #1;

        // latency sweep over unroll factors, bit-exact against the model
        sw_x = W'(K_Q); sw_y = '0; sw_z = W'(PI_2);
        sw_valid = 1'b1;
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        sw_lat = '{0, 0, 0};
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++)
                if (sw_ov[g] && sw_lat[g] == 0) sw_lat[g] = c;
        end
        chk("sweep_lat_ipc1", sw_lat[0], 16);
        chk("sweep_lat_ipc2", sw_lat[1], 8);
        chk("sweep_lat_ipc16", sw_lat[2], 1);
        model(1'b0, W'(K_Q), W'(0), W'(PI_2), ex, ey, ez);
        for (int g = 0; g < 3; g++) begin
            chk("sweep_x", sw_ox[g], ex);
            chk("sweep_y", sw_oy[g], ey);
            chk("sweep_z", sw_oz[g], ez);
        end
        sw_ready = 1'b1;
        @(posedge clk);
        #1;
        sw_ready = 1'b0;
        chk("sweep_consumed", sw_ov, 3'b000);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
